lock_ctrl: RTL and testbench
============================

LOCK_CTRL -- requirements
Module: lock_ctrl

Interface
REQ-001 Parameter PASSWORD, 16'h1234, four BCD digits, most significant digit entered first.
REQ-002 Parameter SCAN_DIV, 4, clock cycles per display scan step (at least 1).
REQ-003 Parameter OPEN_CYCLES, 8, cycles the lock stays open.
REQ-004 Parameter MAX_FAIL, 3, consecutive failures that trigger lockout.
REQ-005 Parameter LOCKOUT_CYCLES, 16, lockout duration in cycles.
REQ-006 clk  input  1  single system clock; all state changes on its rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 key_valid  input  1  one-cycle strobe; key_code is valid.
REQ-009 key_code  input  4  keypad code; 0-9 are digits, 10-15 are ignored.
REQ-010 key_enter  input  1  one-cycle strobe; submit the entry.
REQ-011 key_clear  input  1  one-cycle strobe; discard the entry, or relock when open.
REQ-012 S  output  2  character index for the downstream LOCK glyph decoder.
REQ-013 dig_en  output  4  active-low one-hot digit enable; dig_en[S] = 0.
REQ-014 disp_lock  output  1  1 = show "LOCK", 0 = blank or open indication.
REQ-015 unlocked  output  1  lock actuator; 1 = open.
REQ-016 fail_cnt  output  2  consecutive failed attempts.

Function
REQ-017 FSM states: IDLE, OPEN, LOCKOUT; outputs are registered; no combinational path from inputs to outputs.
REQ-018 IDLE with key_valid and code <= 9: shift the digit into the 16-bit entry buffer and increment the digit count; the count saturates at 4 and a 5th digit is dropped.
REQ-019 IDLE with key_enter, count == 4 and buffer == PASSWORD: go to OPEN; unlocked = 1 on the cycle after the strobe; fail_cnt = 0; buffer cleared.
REQ-020 IDLE with key_enter, any other case (including count < 4): failure; fail_cnt + 1; buffer and count cleared; stay in IDLE.
REQ-021 Same-cycle priority: key_clear > key_enter > key_valid; a lower-priority strobe in the same cycle is discarded.
REQ-022 key_clear in IDLE clears the buffer and count; fail_cnt is unchanged.
REQ-023 OPEN: unlocked = 1 for exactly OPEN_CYCLES cycles, then IDLE; key_clear relocks on the next cycle; digits and enter are ignored.
REQ-024 disp_lock = 1 in IDLE and LOCKOUT, 0 in OPEN.
REQ-025 Scanner: a prescaler advances S once every SCAN_DIV cycles, wraps 3 -> 0, and runs in all states; dig_en = ~(4'b0001 << S).
REQ-026 fail_cnt saturates at 3.

Reset
REQ-027 On rst = 1 at a clock edge: state = IDLE, buffer = 0, count = 0, fail_cnt = 0, S = 0, prescaler = 0, dig_en = 4'b1110, disp_lock = 1, unlocked = 0.
REQ-028 Reset overrides all strobes in the same cycle and takes effect mid-OPEN or mid-LOCKOUT.

Configuration
REQ-029 Macro LOCK_LOCKOUT_EN defined: the failure that makes fail_cnt == MAX_FAIL enters LOCKOUT.
REQ-030 In LOCKOUT all keys are ignored for LOCKOUT_CYCLES cycles, then the FSM returns to IDLE with fail_cnt = 0.
REQ-031 Macro not defined: the LOCKOUT state and its timer are not built; failures only increment fail_cnt (saturating) and the FSM stays in IDLE.

Verification
REQ-032 Reset, then keys 1,2,3,4 and enter -> unlocked = 1 on the next cycle, held 8 cycles, then 0; disp_lock = 0 for the same window.
REQ-033 Keys 1,2,3,5 and enter -> unlocked stays 0, fail_cnt = 1; then 1,2,3,4 and enter -> opens, fail_cnt = 0.
REQ-034 Three wrong entries with LOCK_LOCKOUT_EN -> LOCKOUT; a correct code inside the 16-cycle window is ignored; after the window fail_cnt = 0 and the correct code opens.
REQ-035 Keys 1,2,3,4,9 and enter -> opens (5th digit dropped); key_valid and key_enter in the same cycle -> digit discarded; key_clear during OPEN -> unlocked = 0 on the next cycle.
REQ-036 Scanner free-run with SCAN_DIV = 4 -> S runs 0,1,2,3,0 and changes every 4 cycles; dig_en runs 1110, 1101, 1011, 0111; rst mid-scan -> S = 0 next cycle.

Source files
------------

// File: rtl/lock_ctrl_if.sv
// Keypad / display bundle for the lock controller.
// The keypad side drives the strobes; the controller drives the scan,
// display and actuator outputs.
interface lock_ctrl_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_enter;
    logic       key_clear;
    logic [1:0] S;
    logic [3:0] dig_en;
    logic       disp_lock;
    logic       unlocked;
    logic [1:0] fail_cnt;

    // Keypad / observer side
    modport master (
        output key_valid, key_code, key_enter, key_clear,
        input  S, dig_en, disp_lock, unlocked, fail_cnt
    );

    // Controller side
    modport slave (
        input  key_valid, key_code, key_enter, key_clear,
        output S, dig_en, disp_lock, unlocked, fail_cnt
    );
endinterface

// File: rtl/lock_ctrl.sv
// Keypad combination lock controller.
// Collects four BCD digits, compares them with PASSWORD on enter, opens the
// lock for OPEN_CYCLES cycles and counts consecutive failures. A free-running
// scanner drives the "LOCK" display character index and digit enables.
// Optional macro LOCK_LOCKOUT_EN: the failure that brings fail_cnt to
// MAX_FAIL locks the keypad out for LOCKOUT_CYCLES cycles.
module lock_ctrl #(
    parameter logic [15:0] PASSWORD       = 16'h1234,
    parameter int          SCAN_DIV       = 4,
    parameter int          OPEN_CYCLES    = 8,
    parameter int          MAX_FAIL       = 3,
    parameter int          LOCKOUT_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst,
    lock_ctrl_if.slave   bus
);

    // Parameters below 1 make the timers meaningless; refuse to elaborate.
    if (SCAN_DIV < 1 || OPEN_CYCLES < 1 || MAX_FAIL < 1 || LOCKOUT_CYCLES < 1) begin : g_bad_param
        $error("lock_ctrl: SCAN_DIV, OPEN_CYCLES, MAX_FAIL and LOCKOUT_CYCLES must be >= 1");
    end

    localparam int PW   = (SCAN_DIV > 1)    ? $clog2(SCAN_DIV)    : 1;
    localparam int OT_W = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;
    localparam logic [PW-1:0]   PRE_MAX  = PW'(SCAN_DIV - 1);
    localparam logic [OT_W-1:0] OPEN_TOP = OT_W'(OPEN_CYCLES - 1);
`ifdef LOCK_LOCKOUT_EN
    localparam int LT_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [LT_W-1:0] LOCK_TOP = LT_W'(LOCKOUT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OPEN    = 2'd1
`ifdef LOCK_LOCKOUT_EN
        , ST_LOCKOUT = 2'd2
`endif
    } state_e;

    state_e          state_q,     state_d;
    logic [15:0]     entry_q,     entry_d;
    logic [2:0]      cnt_q,       cnt_d;
    logic [1:0]      fail_cnt_q,  fail_cnt_d;
    logic [OT_W-1:0] open_tmr_q,  open_tmr_d;
`ifdef LOCK_LOCKOUT_EN
    logic [LT_W-1:0] lock_tmr_q,  lock_tmr_d;
`endif
    logic [PW-1:0]   pre_q,       pre_d;
    logic [1:0]      s_q,         s_d;
    logic [3:0]      dig_en_q,    dig_en_d;
    logic            disp_lock_q, disp_lock_d;
    logic            unlocked_q,  unlocked_d;

    logic [1:0]      fail_inc;
    logic            digit_ok;
    logic            code_match;

    // Saturating failure increment and key qualifiers
    assign fail_inc   = (fail_cnt_q == 2'd3) ? 2'd3 : fail_cnt_q + 2'd1;
    assign digit_ok   = bus.key_valid && (bus.key_code <= 4'd9);
    assign code_match = (cnt_q == 3'd4) && (entry_q == PASSWORD);

    // Next-state logic: scanner, lock FSM and registered output values
    always_comb begin
        // NOTE: every target gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        entry_d     = entry_q;
        cnt_d       = cnt_q;
        fail_cnt_d  = fail_cnt_q;
        open_tmr_d  = open_tmr_q;
`ifdef LOCK_LOCKOUT_EN
        lock_tmr_d  = lock_tmr_q;
`endif
        pre_d       = pre_q;
        s_d         = s_q;

        // Scanner runs regardless of lock state
        if (pre_q == PRE_MAX) begin
            pre_d = '0;
            s_d   = s_q + 2'd1;
        end else begin
            pre_d = pre_q + PW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                // clear beats enter beats digit; losers are dropped
                if (bus.key_clear) begin
                    entry_d = '0;
                    cnt_d   = '0;
                end else if (bus.key_enter) begin
                    entry_d = '0;
                    cnt_d   = '0;
                    if (code_match) begin
                        state_d    = ST_OPEN;
                        fail_cnt_d = '0;
                        open_tmr_d = OPEN_TOP;
                    end else begin
                        fail_cnt_d = fail_inc;
`ifdef LOCK_LOCKOUT_EN
                        if (int'(fail_inc) == MAX_FAIL) begin
                            state_d    = ST_LOCKOUT;
                            lock_tmr_d = LOCK_TOP;
                        end
`endif
                    end
                end else if (digit_ok && cnt_q != 3'd4) begin
                    entry_d = {entry_q[11:0], bus.key_code};
                    cnt_d   = cnt_q + 3'd1;
                end
            end

            ST_OPEN: begin
                if (bus.key_clear || open_tmr_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    open_tmr_d = open_tmr_q - OT_W'(1);
                end
            end

`ifdef LOCK_LOCKOUT_EN
            ST_LOCKOUT: begin
                if (lock_tmr_q == '0) begin
                    state_d    = ST_IDLE;
                    fail_cnt_d = '0;
                end else begin
                    lock_tmr_d = lock_tmr_q - LT_W'(1);
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
                entry_d = '0;
                cnt_d   = '0;
            end
        endcase

        // Outputs are computed from next state so they register in step
        dig_en_d    = ~(4'b0001 << s_d);
        unlocked_d  = (state_d == ST_OPEN);
        disp_lock_d = (state_d != ST_OPEN);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q     <= ST_IDLE;
            entry_q     <= '0;
            cnt_q       <= '0;
            fail_cnt_q  <= '0;
            open_tmr_q  <= '0;
`ifdef LOCK_LOCKOUT_EN
            lock_tmr_q  <= '0;
`endif
            pre_q       <= '0;
            s_q         <= '0;
            dig_en_q    <= 4'b1110;
            disp_lock_q <= 1'b1;
            unlocked_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            entry_q     <= entry_d;
            cnt_q       <= cnt_d;
            fail_cnt_q  <= fail_cnt_d;
            open_tmr_q  <= open_tmr_d;
`ifdef LOCK_LOCKOUT_EN
            lock_tmr_q  <= lock_tmr_d;
`endif
            pre_q       <= pre_d;
            s_q         <= s_d;
            dig_en_q    <= dig_en_d;
            disp_lock_q <= disp_lock_d;
            unlocked_q  <= unlocked_d;
        end
    end

    assign bus.S         = s_q;
    assign bus.dig_en    = dig_en_q;
    assign bus.disp_lock = disp_lock_q;
    assign bus.unlocked  = unlocked_q;
    assign bus.fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_lock_ctrl.sv
// Scoreboard bench for lock_ctrl: the stimulus process pushes expected
// output values tagged with the cycle they must appear in; a monitor on the
// falling edge pops and compares them.
module tb_lock_ctrl;

    typedef enum int {F_S, F_DIG, F_LOCK, F_UNL, F_FAIL} field_e;

    typedef struct {
        int         cyc;
        string      name;
        field_e     f;
        logic [3:0] exp;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   flush = 1'b0;
    exp_t sb[$];

    lock_ctrl_if bus ();

    lock_ctrl #(
        .PASSWORD      (16'h1234),
        .SCAN_DIV      (4),
        .OPEN_CYCLES   (8),
        .MAX_FAIL      (3),
        .LOCKOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [3:0] read_field(input field_e f);
        case (f)
            F_S:    return {2'b00, bus.S};
            F_DIG:  return bus.dig_en;
            F_LOCK: return {3'b000, bus.disp_lock};
            F_UNL:  return {3'b000, bus.unlocked};
            F_FAIL: return {2'b00, bus.fail_cnt};
            default: return 4'hx;
        endcase
    endfunction

    // Monitor: compare every expectation due this cycle; stale ones fail
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                check(sb[i].name, read_field(sb[i].f), sb[i].exp);
                sb.delete(i);
            end else if (sb[i].cyc < cyc || flush) begin
                checks++;
                failures++;
                $display("FAIL %s: expectation for cycle %0d never compared (now %0d)",
                         sb[i].name, sb[i].cyc, cyc);
                sb.delete(i);
            end
        end
    end

    task automatic push(input int off, input string name, input field_e f, input logic [3:0] v);
        exp_t e;
        e.cyc  = cyc + off;
        e.name = name;
        e.f    = f;
        e.exp  = v;
        sb.push_back(e);
    endtask

    task automatic expect_out(input int off, input string name,
                              input logic unl, input logic lock, input logic [1:0] fail);
        push(off, {name, ".unlocked"},  F_UNL,  {3'b000, unl});
        push(off, {name, ".disp_lock"}, F_LOCK, {3'b000, lock});
        push(off, {name, ".fail_cnt"},  F_FAIL, {2'b00, fail});
    endtask

    task automatic expect_scan(input int off, input string name, input logic [1:0] s);
        push(off, {name, ".S"},      F_S,   {2'b00, s});
        push(off, {name, ".dig_en"}, F_DIG, ~(4'b0001 << s));
    endtask

    // One clock of stimulus; outputs reflect it once this returns
    task automatic tick(input logic v, input logic [3:0] c, input logic e,
                        input logic cl, input logic r);
        bus.key_valid = v;
        bus.key_code  = c;
        bus.key_enter = e;
        bus.key_clear = cl;
        rst           = r;
        @(posedge clk);
        #1;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'd0;
        bus.key_enter = 1'b0;
        bus.key_clear = 1'b0;
        rst           = 1'b0;
    endtask

    task automatic key(input logic [3:0] k);
        tick(1'b1, k, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic enter();
        tick(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic clear();
        tick(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic keys4(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d);
        key(a); key(b); key(c); key(d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.key_valid = 1'b0;
        bus.key_code  = 4'd0;
        bus.key_enter = 1'b0;
        bus.key_clear = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state and free-running scanner
        expect_out(0, "reset", 1'b0, 1'b1, 2'd0);
        for (int k = 0; k <= 16; k++) begin
            push(k, "scan.S", F_S, 4'((k / 4) % 4));
            if (k % 4 == 0) push(k, "scan.dig_en", F_DIG, ~(4'b0001 << ((k / 4) % 4)));
        end
        idle(17);

        // Correct code with an ignored non-digit; open window of 8 cycles,
        // digits and enter ignored while open
        key(4'd1); key(4'd2); key(4'd12); key(4'd3); key(4'd4);
        expect_out(0, "pre_enter", 1'b0, 1'b1, 2'd0);
        enter();
        for (int k = 0; k < 8; k++) expect_out(k, "open_window", 1'b1, 1'b0, 2'd0);
        expect_out(8, "open_expire", 1'b0, 1'b1, 2'd0);
        key(4'd5);
        enter();
        idle(7);

        // Wrong code counts a failure; correct code then clears it
        keys4(4'd1, 4'd2, 4'd3, 4'd5); enter();
        expect_out(0, "wrong_code", 1'b0, 1'b1, 2'd1);
        keys4(4'd1, 4'd2, 4'd3, 4'd4); enter();
        expect_out(0, "right_after_wrong", 1'b1, 1'b0, 2'd0);
        clear();
        expect_out(0, "clear_relock", 1'b0, 1'b1, 2'd0);
        idle(1);

        // Fifth digit dropped
        keys4(4'd1, 4'd2, 4'd3, 4'd4); key(4'd9); enter();
        expect_out(0, "fifth_digit", 1'b1, 1'b0, 2'd0);
        clear();

        // Digit and enter together: digit discarded, short entry fails
        key(4'd1); key(4'd2); key(4'd3);
        tick(1'b1, 4'd4, 1'b1, 1'b0, 1'b0);
        expect_out(0, "valid_with_enter", 1'b0, 1'b1, 2'd1);
        keys4(4'd1, 4'd2, 4'd3, 4'd4); enter();
        expect_out(0, "reopen", 1'b1, 1'b0, 2'd0);
        clear();

        // Clear and enter together: enter discarded, entry wiped
        keys4(4'd1, 4'd2, 4'd3, 4'd4);
        tick(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        expect_out(0, "clear_with_enter", 1'b0, 1'b1, 2'd0);
        enter();
        expect_out(0, "empty_enter", 1'b0, 1'b1, 2'd1);

        // Clear in idle keeps fail_cnt and wipes the partial entry
        key(4'd1); clear();
        expect_out(0, "idle_clear", 1'b0, 1'b1, 2'd1);
        key(4'd2); key(4'd3); key(4'd4); enter();
        expect_out(0, "partial_wiped", 1'b0, 1'b1, 2'd2);
        keys4(4'd1, 4'd2, 4'd3, 4'd4); enter();
        expect_out(0, "open_resets_fail", 1'b1, 1'b0, 2'd0);
        clear();

`ifdef LOCK_LOCKOUT_EN
        // Third failure locks out; keys ignored for 16 cycles
        enter(); expect_out(0, "fail1", 1'b0, 1'b1, 2'd1);
        enter(); expect_out(0, "fail2", 1'b0, 1'b1, 2'd2);
        enter();
        expect_out(0,  "lockout_entry", 1'b0, 1'b1, 2'd3);
        expect_out(15, "lockout_last",  1'b0, 1'b1, 2'd3);
        expect_out(16, "lockout_exit",  1'b0, 1'b1, 2'd0);
        keys4(4'd1, 4'd2, 4'd3, 4'd4); enter();
        expect_out(0, "lockout_ignores_code", 1'b0, 1'b1, 2'd3);
        idle(11);
        keys4(4'd1, 4'd2, 4'd3, 4'd4); enter();
        expect_out(0, "open_after_lockout", 1'b1, 1'b0, 2'd0);
        clear();
`else
        // Failures saturate at 3 and the keypad stays live
        enter(); expect_out(0, "fail1", 1'b0, 1'b1, 2'd1);
        enter(); expect_out(0, "fail2", 1'b0, 1'b1, 2'd2);
        enter(); expect_out(0, "fail3", 1'b0, 1'b1, 2'd3);
        enter(); expect_out(0, "fail_sat", 1'b0, 1'b1, 2'd3);
        keys4(4'd1, 4'd2, 4'd3, 4'd4); enter();
        expect_out(0, "open_after_fails", 1'b1, 1'b0, 2'd0);
        clear();
`endif

        // Reset beats enter in the same cycle and wipes the entry
        keys4(4'd1, 4'd2, 4'd3, 4'd4);
        tick(1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
        expect_out(0, "rst_with_enter", 1'b0, 1'b1, 2'd0);
        expect_scan(0, "rst_with_enter", 2'd0);
        enter();
        expect_out(0, "entry_wiped_by_rst", 1'b0, 1'b1, 2'd1);

        // Reset mid-open and mid-scan
        keys4(4'd1, 4'd2, 4'd3, 4'd4); enter();
        idle(2);
        for (int i = 0; i < 5 && bus.S == 2'd0; i++) idle(1);
        expect_out(0, "before_rst_open", 1'b1, 1'b0, 2'd0);
        idle(1);
        tick(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        expect_out(0, "rst_mid_open", 1'b0, 1'b1, 2'd0);
        expect_scan(0, "rst_mid_scan", 2'd0);
        push(3, "post_rst_hold.S", F_S, 4'd0);
        expect_scan(4, "post_rst_step", 2'd1);
        idle(5);

        // Drain anything still pending, then flag leftovers
        for (int i = 0; i < 40 && sb.size() > 0; i++) @(posedge clk);
        flush = 1'b1;
        @(negedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
